// File: rtl/sram_port_ctrl_pkg.sv
// Shared types and constants for the dual asynchronous SRAM port controller.
// State encodings, strobe polarity, bank-select bit and default timings.
package sram_port_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_PULSE  = 3'd2,
    W_HOLD   = 3'd3,
    R_ACCESS = 3'd4
  } state_t;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam int BANK_BIT      = 16;
  localparam int DEF_WE_CYCLES = 2;
  localparam int DEF_RD_CYCLES = 2;

  // Counter only ever holds (cycles - 1), so clog2 of the max is enough.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sram_port_ctrl_bank_port.sv
// One SRAM bank's pin driver: strobes, address, tri-state data and read tap.
// All pins are idle unless this bank is selected and an access is active.
module sram_bank_port
  import sram_port_ctrl_pkg::*;
(
  input  logic        sel,
  input  logic        act,
  input  logic        oe_ph,
  input  logic        we_ph,
  input  logic        drv,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [17:0] ram_addr,
  inout  wire  [15:0] ram_data,
  output logic        ram_en,
  output logic        ram_oe,
  output logic        ram_we
);

  logic on;

  assign on = sel && act;

  assign ram_en = on ? STROBE_ON : STROBE_OFF;
  assign ram_oe = (on && oe_ph) ? STROBE_ON : STROBE_OFF;
  assign ram_we = (on && we_ph) ? STROBE_ON : STROBE_OFF;

  assign ram_addr = on ? {2'b00, addr} : 18'd0;

  // drv is never set in the OE phase, so the bus and OE cannot fight.
  assign ram_data = (on && drv) ? wdata : 16'bz;
  assign rdata    = ram_data;

endmodule

// File: rtl/sram_port_ctrl.sv
// Sequences single-cycle read/write requests into SRAM strobe timing
// for two banks, returning a done pulse and registered read data.
module sram_port_ctrl
  import sram_port_ctrl_pkg::*;
#(
  parameter int WE_CYCLES = DEF_WE_CYCLES,
  parameter int RD_CYCLES = DEF_RD_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        re,
  input  logic        we,
  input  logic [16:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        busy,
  output logic [17:0] ram1_addr,
  output logic [17:0] ram2_addr,
  inout  wire  [15:0] ram1_data,
  inout  wire  [15:0] ram2_data,
  output logic        ram1EN,
  output logic        ram1OE,
  output logic        ram1WE,
  output logic        ram2EN,
  output logic        ram2OE,
  output logic        ram2WE
);

  localparam int CW = cnt_width(WE_CYCLES, RD_CYCLES);
  localparam logic [CW-1:0] WE_LOAD = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_d;
  logic          accept;
  logic          capture;
  logic [16:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          act, oe_ph, we_ph, drv, sel2;
  logic [15:0]   rd1, rd2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && (re || we)) begin
          accept  = 1'b1;
          state_d = we ? W_SETUP : R_ACCESS;
          cnt_d   = we ? '0 : RD_LOAD;
        end
      end
      W_SETUP: begin
        state_d = W_PULSE;
        cnt_d   = WE_LOAD;
      end
      W_PULSE: begin
        if (cnt_q == '0) state_d = W_HOLD;
        else cnt_d = cnt_q - 1'b1;
      end
      W_HOLD: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      R_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_out <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= data_in;
      end
      if (capture) data_out <= sel2 ? rd2 : rd1;
    end
  end

  assign act   = (state_q != IDLE);
  assign oe_ph = (state_q == R_ACCESS);
  assign we_ph = (state_q == W_PULSE);
  assign drv   = act && !oe_ph;
  assign busy  = act;
  assign sel2  = addr_q[BANK_BIT];

  sram_bank_port u_bank1 (
    .sel      (!sel2),
    .act      (act),
    .oe_ph    (oe_ph),
    .we_ph    (we_ph),
    .drv      (drv),
    .addr     (addr_q[15:0]),
    .wdata    (wdata_q),
    .rdata    (rd1),
    .ram_addr (ram1_addr),
    .ram_data (ram1_data),
    .ram_en   (ram1EN),
    .ram_oe   (ram1OE),
    .ram_we   (ram1WE)
  );

  sram_bank_port u_bank2 (
    .sel      (sel2),
    .act      (act),
    .oe_ph    (oe_ph),
    .we_ph    (we_ph),
    .drv      (drv),
    .addr     (addr_q[15:0]),
    .wdata    (wdata_q),
    .rdata    (rd2),
    .ram_addr (ram2_addr),
    .ram_data (ram2_data),
    .ram_en   (ram2EN),
    .ram_oe   (ram2OE),
    .ram_we   (ram2WE)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: two SRAM device models plus a cycle-indexed
// expectation of every strobe, address, bus and handshake output.
module tb_sram_port_ctrl;

  localparam int WEC = 2;
  localparam int RDC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, re, we;
  logic [16:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        done, busy;
  logic [17:0] ram1_addr, ram2_addr;
  wire  [15:0] ram1_data, ram2_data;
  logic        ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] dev1 [1024];
  logic [15:0] dev2 [1024];
  logic [15:0] ref_mem [2048];
  logic [15:0] exp_dout;

  sram_port_ctrl #(.WE_CYCLES(WEC), .RD_CYCLES(RDC)) dut (
    .clk(clk), .rst(rst), .en(en), .re(re), .we(we),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .done(done), .busy(busy),
    .ram1_addr(ram1_addr), .ram2_addr(ram2_addr),
    .ram1_data(ram1_data), .ram2_data(ram2_data),
    .ram1EN(ram1EN), .ram1OE(ram1OE), .ram1WE(ram1WE),
    .ram2EN(ram2EN), .ram2OE(ram2OE), .ram2WE(ram2WE)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM devices: drive on EN&OE, latch while EN&WE low.
  assign ram1_data = (!ram1EN && !ram1OE) ? dev1[ram1_addr[9:0]] : 16'bz;
  assign ram2_data = (!ram2EN && !ram2OE) ? dev2[ram2_addr[9:0]] : 16'bz;

  always @(posedge clk) begin
    if (!ram1EN && !ram1WE) dev1[ram1_addr[9:0]] = ram1_data;
    if (!ram2EN && !ram2WE) dev2[ram2_addr[9:0]] = ram2_data;
  end

  // One request issued in the current cycle (cycle 0), then checks each
  // following cycle against the timing rules up to and including done.
  task automatic do_op(input logic op_en, input logic op_re,
                       input logic op_we, input logic [16:0] a,
                       input logic [15:0] d, input bit inject);
    bit valid, is_wr, act, oel, wel, drv, dn, bsy;
    int n, idx;
    logic [5:0] exp_s, got_s;
    logic [17:0] e_a1, e_a2, ea;
    logic [15:0] bus;
    valid = op_en && (op_re || op_we);
    is_wr = op_we;
    n = !valid ? 2 : (is_wr ? WEC + 3 : RDC + 1);
    idx = {a[16], a[9:0]};
    en = op_en; re = op_re; we = op_we; addr = a; data_in = d;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      act = 0; oel = 0; wel = 0; drv = 0; dn = 0;
      if (valid && is_wr) begin
        act = (k >= 1) && (k <= WEC + 2);
        wel = (k >= 2) && (k <= WEC + 1);
        drv = act;
        dn  = (k == WEC + 3);
      end else if (valid) begin
        act = (k <= RDC);
        oel = act;
        dn  = (k == RDC + 1);
      end
      bsy = valid && (k < n);
      if (dn && is_wr) ref_mem[idx] = d;
      if (dn && !is_wr) exp_dout = ref_mem[idx];
      exp_s = {~(act && !a[16]), ~(oel && !a[16]), ~(wel && !a[16]),
               ~(act && a[16]), ~(oel && a[16]), ~(wel && a[16])};
      got_s = {ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE};
      ea = {2'b00, a[15:0]};
      e_a1 = (act && !a[16]) ? ea : 18'd0;
      e_a2 = (act && a[16]) ? ea : 18'd0;
      n_cmp++;
      if (got_s !== exp_s) begin
        n_bad++;
        $display("FAIL strobes a=%h k=%0d got %b want %b", a, k, got_s, exp_s);
      end
      n_cmp++;
      if (done !== dn) begin
        n_bad++;
        $display("FAIL done a=%h k=%0d got %b want %b", a, k, done, dn);
      end
      n_cmp++;
      if (busy !== bsy) begin
        n_bad++;
        $display("FAIL busy a=%h k=%0d got %b want %b", a, k, busy, bsy);
      end
      n_cmp++;
      if (data_out !== exp_dout) begin
        n_bad++;
        $display("FAIL data_out a=%h k=%0d got %h want %h", a, k, data_out, exp_dout);
      end
      n_cmp++;
      if (ram1_addr !== e_a1 || ram2_addr !== e_a2) begin
        n_bad++;
        $display("FAIL ram_addr a=%h k=%0d got %h/%h want %h/%h",
                 a, k, ram1_addr, ram2_addr, e_a1, e_a2);
      end
      if (drv) begin
        bus = a[16] ? ram2_data : ram1_data;
        n_cmp++;
        if (bus !== d) begin
          n_bad++;
          $display("FAIL wr_bus a=%h k=%0d got %h want %h", a, k, bus, d);
        end
      end
      if (k == 1) begin
        en = 0; re = 0; we = 0;
        addr = 17'($urandom); data_in = 16'($urandom);
      end
      if (inject && k == 2) begin en = 1; we = 1; end
      if (inject && k == 3) begin en = 0; we = 0; end
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE} !== 6'b111111) begin
      n_bad++;
      $display("FAIL reset_strobes got %b want 111111",
               {ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE});
    end
    n_cmp++;
    if (ram1_addr !== 18'd0 || ram2_addr !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_addr got %h/%h want 0/0", ram1_addr, ram2_addr);
    end
    n_cmp++;
    if ({done, busy, data_out} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_outs got done=%b busy=%b dout=%h want 0",
               done, busy, data_out);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_write_bank1;
    do_op(1, 0, 1, 17'h00005, 16'h1234, 0);
  endtask

  task automatic test_write_read_bank2;
    do_op(1, 0, 1, 17'h10005, 16'hABCD, 0);
    do_op(1, 1, 0, 17'h10005, 16'h0000, 0);
    n_cmp++;
    if (data_out !== 16'hABCD) begin
      n_bad++;
      $display("FAIL bank2_readback got %h want abcd", data_out);
    end
  endtask

  task automatic test_both_req;
    do_op(1, 1, 1, 17'h00003, 16'h5555, 0);
  endtask

  task automatic test_drop;
    do_op(1, 1, 0, 17'h00005, 16'h0000, 1);
    do_op(0, 1, 0, 17'h00003, 16'h0000, 0);
    do_op(0, 0, 1, 17'h10007, 16'h7777, 0);
  endtask

  task automatic test_reset_mid;
    en = 1; we = 1; re = 0; addr = 17'h00300; data_in = 16'hBEEF;
    @(negedge clk);
    en = 0; we = 0;
    @(negedge clk);
    n_cmp++;
    if (ram1WE !== 1'b0) begin
      n_bad++;
      $display("FAIL pulse_before_rst got %b want 0", ram1WE);
    end
    #2 rst = 0;
    #1;
    n_cmp++;
    if ({ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE} !== 6'b111111
        || busy !== 1'b0 || ram1_addr !== 18'd0) begin
      n_bad++;
      $display("FAIL mid_reset got strobes=%b busy=%b addr=%h want 111111/0/0",
               {ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}, busy, ram1_addr);
    end
    exp_dout = 16'h0000;
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || ram1EN !== 1'b1) begin
        n_bad++;
        $display("FAIL post_reset k=%0d got done=%b busy=%b en=%b want 0/0/1",
                 k, done, busy, ram1EN);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++)
      do_op(1, 0, 1, 17'(i), 16'h0100 + 16'(i), 0);
    for (int i = 0; i < 10; i++) begin
      do_op(1, 1, 0, 17'(i), 16'h0000, 0);
      n_cmp++;
      if (data_out !== 16'h0100 + 16'(i)) begin
        n_bad++;
        $display("FAIL b2b_readback i=%0d got %h want %h",
                 i, data_out, 16'h0100 + 16'(i));
      end
    end
  endtask

  task automatic test_random;
    logic [16:0] a;
    logic r_en, r_re, r_we;
    for (int i = 0; i < 60; i++) begin
      a = {1'($urandom), 8'h00, 8'($urandom)};
      r_en = ($urandom_range(0, 7) != 0);
      r_re = 1'($urandom);
      r_we = 1'($urandom);
      do_op(r_en, r_re, r_we, a, 16'($urandom), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dev1[i] = 16'h0000;
      dev2[i] = 16'h0000;
    end
    for (int i = 0; i < 2048; i++) ref_mem[i] = 16'h0000;
    exp_dout = 16'h0000;
    rst = 0; en = 0; re = 0; we = 0; addr = '0; data_in = '0;
    test_reset();
    test_write_bank1();
    test_write_read_bank2();
    test_both_req();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
